load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the execute stage and the word-addressed data memory (32-bit words, 8-bit word address, `Mem_Write`/`Mem_Read` strobes). It turns byte/halfword/word load and store requests into memory cycles. Sub-word stores use read-modify-write. Loads are returned sign- or zero-extended. It uses a valid/ready request handshake and a single-cycle response pulse, and has one transaction in flight at a time.

## Interface
- `DATA_WIDTH`, 32: memory word width; fixed at 32 for byte-lane logic.
- `ADDR_WIDTH`, 8: memory word-address width. The byte address is `ADDR_WIDTH+2` bits.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `Req_Valid` in 1: request present.
- `Req_Ready` out 1: unit idle, request accepted on `Req_Valid && Req_Ready` at posedge.
- `Req_Write` in 1: 1 = store, 0 = load.
- `Req_Size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `Req_Unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `Req_Addr` in `ADDR_WIDTH+2`: byte address.
- `Req_Wdata` in 32: store data, right-justified.
- `Resp_Valid` out 1: one-cycle completion pulse.
- `Resp_Rdata` out 32: load result; 0 for stores and errors.
- `Resp_Error` out 1: valid with `Resp_Valid`; misaligned or illegal size.
- `Mem_Address` out `ADDR_WIDTH`: word address, equal to `Req_Addr[ADDR_WIDTH+1:2]`.
- `Mem_Write_Data` out 32: word to store.
- `Mem_Write` out 1: memory write strobe.
- `Mem_Read` out 1: memory read strobe.
- `Mem_Read_Data` in 32: memory read word, valid the cycle after `Mem_Read` is first sampled.

## Operation
- All outputs are registered.
- Reset values:
  - `Req_Ready`=0, `Resp_Valid`=0, `Resp_Rdata`=0, `Resp_Error`=0.
  - `Mem_*` outputs all 0.
  - State IDLE.
  - `Req_Ready` rises at the first posedge after `rst_n` deasserts.
- FSM states: IDLE, RD, CAP, WR, RESP.
- IDLE: `Req_Ready`=1. On accept, latch all `Req_*`.
  - Error (see Configuration) → RESP.
  - Word store → WR.
  - Any other access → RD.
- RD: `Mem_Read`=1 and `Mem_Address` driven → CAP.
- CAP: `Mem_Read` held at 1. Capture `Mem_Read_Data`.
  - Load: extract lane and extend → RESP.
  - Sub-word store: merge → WR.
- WR: `Mem_Write`=1 for exactly one cycle with the merged or full word → RESP.
- RESP: `Resp_Valid`=1 for one cycle → IDLE. `Req_Ready` is 0 in all states except IDLE.
- Byte lanes are little-endian.
  - Byte lane n = `Req_Addr[1:0]`, bits [8n+7:8n].
  - Half lane h = `Req_Addr[1]`, bits [16h+15:16h].
  - Stores replace only the selected lane and preserve the other bytes of the read word.
- `Resp_Rdata` and `Resp_Error` hold their values until the next `Resp_Valid`.
- `Mem_Address` and `Mem_Write_Data` hold their last values when the strobes are low.

## Timing
- Latency counts posedges from the accept edge to the edge where `Resp_Valid` is first sampled high:
  - load: 3 (RD, CAP, RESP);
  - word store: 2 (WR, RESP);
  - sub-word store: 4 (RD, CAP, WR, RESP);
  - error: 1.
- Back-to-back throughput: `Req_Ready` returns the cycle after RESP, so there is one idle-accept cycle between transactions.
- `Req_Valid` while `Req_Ready`=0 is ignored. The requester holds `Req_*` stable until accepted. Changes after acceptance have no effect.
- `Mem_Read` and `Mem_Write` are never high in the same cycle.
- Address wrap: the top word address passes through unchanged; there is no wrap logic.
- Reset mid-operation forces IDLE and drops all strobes immediately (asynchronously).
  - No `Resp_Valid` is issued for the aborted request.
  - A WR cycle interrupted by reset may or may not have updated memory.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - Half with `Req_Addr[0]`=1, word with `Req_Addr[1:0]`≠0, or `Req_Size`=11 → RESP with `Resp_Error`=1 and `Resp_Rdata`=0.
  - No memory strobe is issued.
- Undefined:
  - Low address bits are forced aligned: half ignores bit 0, word ignores bits 1:0.
  - `Req_Size`=11 is treated as word.
  - `Resp_Error` is tied to 0.

## Test plan
- Word store 0xA5A5A5A5 to byte addr 0x040 → one `Mem_Write` at `Mem_Address`=0x10 with data 0xA5A5A5A5. `Resp_Valid` 2 cycles after accept, `Resp_Error`=0.
- Byte store 0x3C to 0x042 over word 0xA5A5A5A5 → RD then WR at 0x10 writing 0xA53CA5A5. `Resp_Valid` after 4 cycles.
- Byte load from 0x043 with word 0xA53CA5A5:
  - signed → `Resp_Rdata`=0xFFFFFFA5;
  - `Req_Unsigned`=1 → 0x000000A5;
  - latency 3.
- Half load from 0x046, signed, with word 0x80015A5A at 0x11 → 0xFFFF8001. Half load from 0x044 → 0x00005A5A.
- With `LSU_ALIGN_CHECK_EN`: word load at 0x041 → `Resp_Error`=1, `Resp_Rdata`=0, latency 1, no `Mem_Read`/`Mem_Write`. Without the macro, the same request reads word 0x10.
- Assert `rst_n`=0 in the CAP state of a sub-word store → `Mem_Read` drops immediately, no WR and no `Resp_Valid`. `Req_Ready`=1 at the first posedge after release.

Source files
------------

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit in front of a word-addressed memory; sub-word stores use read-modify-write.
// Latency load 3, word store 2, sub-word store 4, error 1; one request in flight, Req_Ready low while busy. Optional LSU_ALIGN_CHECK_EN.
module load_store_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    Req_Valid,
   output logic                    Req_Ready,
   input  logic                    Req_Write,
   input  logic [1:0]              Req_Size,
   input  logic                    Req_Unsigned,
   input  logic [ADDR_WIDTH+1:0]   Req_Addr,
   input  logic [DATA_WIDTH-1:0]   Req_Wdata,
   output logic                    Resp_Valid,
   output logic [DATA_WIDTH-1:0]   Resp_Rdata,
   output logic                    Resp_Error,
   output logic [ADDR_WIDTH-1:0]   Mem_Address,
   output logic [DATA_WIDTH-1:0]   Mem_Write_Data,
   output logic                    Mem_Write,
   output logic                    Mem_Read,
   input  logic [DATA_WIDTH-1:0]   Mem_Read_Data
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_WR,
      S_RESP
   } state_t;

   state_t                  state_q;
   logic                    ready_q;
   logic                    write_q;
   logic [1:0]              size_q;
   logic                    unsigned_q;
   logic [1:0]              lane_q;
   logic [15:0]             wdata_q;
   logic                    resp_vld_q;
   logic [DATA_WIDTH-1:0]   resp_rdata_q;
   logic                    resp_err_q;
   logic [ADDR_WIDTH-1:0]   mem_addr_q;
   logic [DATA_WIDTH-1:0]   mem_wdata_q;
   logic                    mem_wr_q;
   logic                    mem_rd_q;

   logic                    req_err;
   logic                    req_word;
   logic [7:0]              byte_sel;
   logic [15:0]             half_sel;
   logic [DATA_WIDTH-1:0]   load_data;
   logic [DATA_WIDTH-1:0]   merge_data;

`ifdef LSU_ALIGN_CHECK_EN
   assign req_err = (Req_Size == 2'b11)
                 || ((Req_Size == 2'b01) && Req_Addr[0])
                 || ((Req_Size == 2'b10) && (Req_Addr[1:0] != 2'b00));
`else
   // Without the check, low address bits are simply ignored by the lane logic.
   assign req_err = 1'b0;
`endif

   // Size 11 only reaches here as a word when the alignment check is disabled.
   assign req_word = Req_Size[1];

   always_comb begin
      byte_sel = Mem_Read_Data[7:0];
      case (lane_q)
         2'd1:    byte_sel = Mem_Read_Data[15:8];
         2'd2:    byte_sel = Mem_Read_Data[23:16];
         2'd3:    byte_sel = Mem_Read_Data[31:24];
         default: byte_sel = Mem_Read_Data[7:0];
      endcase
      half_sel = lane_q[1] ? Mem_Read_Data[31:16] : Mem_Read_Data[15:0];

      load_data = Mem_Read_Data;
      if (!size_q[1]) begin
         if (size_q[0]) begin
            load_data = {{(DATA_WIDTH-16){half_sel[15] & ~unsigned_q}}, half_sel};
         end else begin
            load_data = {{(DATA_WIDTH-8){byte_sel[7] & ~unsigned_q}}, byte_sel};
         end
      end

      merge_data = Mem_Read_Data;
      if (size_q[0]) begin
         if (lane_q[1]) begin
            merge_data[31:16] = wdata_q;
         end else begin
            merge_data[15:0] = wdata_q;
         end
      end else begin
         case (lane_q)
            2'd1:    merge_data[15:8]  = wdata_q[7:0];
            2'd2:    merge_data[23:16] = wdata_q[7:0];
            2'd3:    merge_data[31:24] = wdata_q[7:0];
            default: merge_data[7:0]   = wdata_q[7:0];
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         ready_q      <= 1'b0;
         write_q      <= 1'b0;
         size_q       <= 2'b00;
         unsigned_q   <= 1'b0;
         lane_q       <= 2'b00;
         wdata_q      <= '0;
         resp_vld_q   <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wr_q     <= 1'b0;
         mem_rd_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (Req_Valid && ready_q) begin
                  ready_q    <= 1'b0;
                  write_q    <= Req_Write;
                  size_q     <= Req_Size;
                  unsigned_q <= Req_Unsigned;
                  lane_q     <= Req_Addr[1:0];
                  wdata_q    <= Req_Wdata[15:0];
                  if (req_err) begin
                     resp_vld_q   <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= '0;
                     state_q      <= S_RESP;
                  end else begin
                     mem_addr_q <= Req_Addr[ADDR_WIDTH+1:2];
                     if (Req_Write && req_word) begin
                        mem_wr_q    <= 1'b1;
                        mem_wdata_q <= Req_Wdata;
                        state_q     <= S_WR;
                     end else begin
                        mem_rd_q <= 1'b1;
                        state_q  <= S_RD;
                     end
                  end
               end else begin
                  ready_q <= 1'b1;
               end
            end
            S_RD: begin
               state_q <= S_CAP;
            end
            S_CAP: begin
               mem_rd_q <= 1'b0;
               if (write_q) begin
                  mem_wr_q    <= 1'b1;
                  mem_wdata_q <= merge_data;
                  state_q     <= S_WR;
               end else begin
                  resp_vld_q   <= 1'b1;
                  resp_err_q   <= 1'b0;
                  resp_rdata_q <= load_data;
                  state_q      <= S_RESP;
               end
            end
            S_WR: begin
               mem_wr_q     <= 1'b0;
               resp_vld_q   <= 1'b1;
               resp_err_q   <= 1'b0;
               resp_rdata_q <= '0;
               state_q      <= S_RESP;
            end
            S_RESP: begin
               resp_vld_q <= 1'b0;
               ready_q    <= 1'b1;
               state_q    <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign Req_Ready      = ready_q;
   assign Resp_Valid     = resp_vld_q;
   assign Resp_Rdata     = resp_rdata_q;
   assign Resp_Error     = resp_err_q;
   assign Mem_Address    = mem_addr_q;
   assign Mem_Write_Data = mem_wdata_q;
   assign Mem_Write      = mem_wr_q;
   assign Mem_Read       = mem_rd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit with a word-addressed memory model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        Req_Valid = 1'b0;
   logic        Req_Ready;
   logic        Req_Write = 1'b0;
   logic [1:0]  Req_Size = 2'b00;
   logic        Req_Unsigned = 1'b0;
   logic [9:0]  Req_Addr = '0;
   logic [31:0] Req_Wdata = '0;
   logic        Resp_Valid;
   logic [31:0] Resp_Rdata;
   logic        Resp_Error;
   logic [7:0]  Mem_Address;
   logic [31:0] Mem_Write_Data;
   logic        Mem_Write;
   logic        Mem_Read;
   logic [31:0] Mem_Read_Data = '0;

   int checks = 0;
   int failures = 0;
   int rd_cnt = 0;
   int wr_cnt = 0;
   int overlap_cnt = 0;

   logic [31:0] mem [256];

   always #5 clk = ~clk;

   load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .Req_Valid      (Req_Valid),
      .Req_Ready      (Req_Ready),
      .Req_Write      (Req_Write),
      .Req_Size       (Req_Size),
      .Req_Unsigned   (Req_Unsigned),
      .Req_Addr       (Req_Addr),
      .Req_Wdata      (Req_Wdata),
      .Resp_Valid     (Resp_Valid),
      .Resp_Rdata     (Resp_Rdata),
      .Resp_Error     (Resp_Error),
      .Mem_Address    (Mem_Address),
      .Mem_Write_Data (Mem_Write_Data),
      .Mem_Write      (Mem_Write),
      .Mem_Read       (Mem_Read),
      .Mem_Read_Data  (Mem_Read_Data)
   );

   // Read data appears the cycle after Mem_Read is sampled.
   always @(posedge clk) begin
      if (Mem_Write) mem[Mem_Address] <= Mem_Write_Data;
      if (Mem_Read)  Mem_Read_Data <= mem[Mem_Address];
      if (Mem_Read)  rd_cnt <= rd_cnt + 1;
      if (Mem_Write) wr_cnt <= wr_cnt + 1;
   end

   always @(negedge clk) begin
      if (Mem_Read && Mem_Write) overlap_cnt <= overlap_cnt + 1;
   end

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic        uns;
      logic [9:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_rd;
      int          exp_wr;
      logic        chk_en;
      logic [7:0]  chk_addr;
      logic [31:0] chk_val;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic add(input logic wr, input logic [1:0] size, input logic uns, input logic [9:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err,
                      input int exp_lat, input int exp_rd, input int exp_wr,
                      input logic chk_en, input logic [7:0] chk_addr, input logic [31:0] chk_val);
      vec_t v;
      v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
      v.exp_rd = exp_rd; v.exp_wr = exp_wr;
      v.chk_en = chk_en; v.chk_addr = chk_addr; v.chk_val = chk_val;
      vecs.push_back(v);
   endtask

   task automatic accept(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [9:0] addr, input logic [31:0] wdata);
      int w;
      @(negedge clk);
      Req_Valid = 1'b1; Req_Write = wr; Req_Size = size; Req_Unsigned = uns;
      Req_Addr = addr; Req_Wdata = wdata;
      w = 0;
      while (!Req_Ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!Req_Ready) chk("accept_timeout", {31'd0, Req_Ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      // Scramble request fields after acceptance; they must have no effect.
      Req_Valid = 1'b0; Req_Write = ~wr; Req_Size = ~size; Req_Addr = ~addr; Req_Wdata = $urandom;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int lat, rd0, wr0;
      string tag;
      tag = $sformatf("v%0d", idx);
      rd0 = rd_cnt; wr0 = wr_cnt;
      accept(v.wr, v.size, v.uns, v.addr, v.wdata);
      lat = 1;
      while (!Resp_Valid && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, lat, v.exp_lat);
      chk({tag, "_rdata"}, Resp_Rdata, v.exp_rdata);
      chk({tag, "_error"}, {31'd0, Resp_Error}, {31'd0, v.exp_err});
      @(negedge clk);
      chk({tag, "_valid_pulse"}, {31'd0, Resp_Valid}, 32'd0);
      chk({tag, "_ready_back"}, {31'd0, Req_Ready}, 32'd1);
      chk({tag, "_rdata_hold"}, Resp_Rdata, v.exp_rdata);
      chk({tag, "_reads"}, rd_cnt - rd0, v.exp_rd);
      chk({tag, "_writes"}, wr_cnt - wr0, v.exp_wr);
      if (v.chk_en) chk({tag, "_mem"}, mem[v.chk_addr], v.chk_val);
   endtask

   initial begin
      //   wr size uns addr    wdata         exp_rdata     err lat rd wr chk addr   value
      add(1, 2'b10, 0, 10'h040, 32'hA5A5A5A5, 32'h00000000, 0, 2, 0, 1, 1, 8'h10, 32'hA5A5A5A5);
      add(1, 2'b00, 0, 10'h042, 32'h0000003C, 32'h00000000, 0, 4, 2, 1, 1, 8'h10, 32'hA53CA5A5);
      add(0, 2'b00, 0, 10'h043, 32'h0,        32'hFFFFFFA5, 0, 3, 2, 0, 0, 8'h00, 32'h0);
      add(0, 2'b00, 1, 10'h043, 32'h0,        32'h000000A5, 0, 3, 2, 0, 0, 8'h00, 32'h0);
      add(0, 2'b00, 0, 10'h042, 32'h0,        32'h0000003C, 0, 3, 2, 0, 0, 8'h00, 32'h0);
      add(1, 2'b10, 0, 10'h044, 32'h80015A5A, 32'h00000000, 0, 2, 0, 1, 1, 8'h11, 32'h80015A5A);
      add(0, 2'b01, 0, 10'h046, 32'h0,        32'hFFFF8001, 0, 3, 2, 0, 0, 8'h00, 32'h0);
      add(0, 2'b01, 0, 10'h044, 32'h0,        32'h00005A5A, 0, 3, 2, 0, 0, 8'h00, 32'h0);
      add(0, 2'b01, 1, 10'h046, 32'h0,        32'h00008001, 0, 3, 2, 0, 0, 8'h00, 32'h0);
      add(1, 2'b01, 0, 10'h044, 32'h1234BEEF, 32'h00000000, 0, 4, 2, 1, 1, 8'h11, 32'h8001BEEF);
      add(0, 2'b10, 0, 10'h044, 32'h0,        32'h8001BEEF, 0, 3, 2, 0, 0, 8'h00, 32'h0);
      add(1, 2'b00, 0, 10'h045, 32'hFFFFFF77, 32'h00000000, 0, 4, 2, 1, 1, 8'h11, 32'h800177EF);
      add(0, 2'b10, 0, 10'h044, 32'h0,        32'h800177EF, 0, 3, 2, 0, 0, 8'h00, 32'h0);
      add(1, 2'b10, 0, 10'h3FC, 32'h12345678, 32'h00000000, 0, 2, 0, 1, 1, 8'hFF, 32'h12345678);
      add(0, 2'b00, 0, 10'h3FF, 32'h0,        32'h00000012, 0, 3, 2, 0, 0, 8'h00, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
      add(0, 2'b10, 0, 10'h041, 32'h0,        32'h00000000, 1, 1, 0, 0, 0, 8'h00, 32'h0);
      add(0, 2'b11, 0, 10'h040, 32'h0,        32'h00000000, 1, 1, 0, 0, 0, 8'h00, 32'h0);
      add(0, 2'b01, 0, 10'h045, 32'h0,        32'h00000000, 1, 1, 0, 0, 0, 8'h00, 32'h0);
      add(1, 2'b10, 0, 10'h046, 32'hDEADDEAD, 32'h00000000, 1, 1, 0, 0, 1, 8'h11, 32'h800177EF);
`else
      add(0, 2'b10, 0, 10'h041, 32'h0,        32'hA53CA5A5, 0, 3, 2, 0, 0, 8'h00, 32'h0);
      add(0, 2'b11, 0, 10'h040, 32'h0,        32'hA53CA5A5, 0, 3, 2, 0, 0, 8'h00, 32'h0);
      add(0, 2'b01, 0, 10'h045, 32'h0,        32'h000077EF, 0, 3, 2, 0, 0, 8'h00, 32'h0);
      add(1, 2'b10, 0, 10'h046, 32'hDEADDEAD, 32'h00000000, 0, 2, 0, 1, 1, 8'h11, 32'hDEADDEAD);
`endif

      // Reset state
      #2;
      chk("rst_req_ready", {31'd0, Req_Ready}, 32'd0);
      chk("rst_resp_valid", {31'd0, Resp_Valid}, 32'd0);
      chk("rst_resp_rdata", Resp_Rdata, 32'd0);
      chk("rst_resp_error", {31'd0, Resp_Error}, 32'd0);
      chk("rst_mem_strobes", {30'd0, Mem_Read, Mem_Write}, 32'd0);
      chk("rst_mem_addr", {24'd0, Mem_Address}, 32'd0);
      chk("rst_mem_wdata", Mem_Write_Data, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("ready_before_edge", {31'd0, Req_Ready}, 32'd0);
      @(negedge clk);
      chk("ready_after_release", {31'd0, Req_Ready}, 32'd1);

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // Reset while a byte store sits in CAP: mem[0x10] is A53CA5A5 here.
      begin
         int wr0;
         wr0 = wr_cnt;
         accept(1'b1, 2'b00, 1'b0, 10'h040, 32'h00000011);
         chk("abort_rd_state", {31'd0, Mem_Read}, 32'd1);
         @(negedge clk);
         chk("abort_cap_state", {31'd0, Mem_Read}, 32'd1);
         rst_n = 1'b0;
         #1;
         chk("abort_read_drop", {31'd0, Mem_Read}, 32'd0);
         chk("abort_write_low", {31'd0, Mem_Write}, 32'd0);
         chk("abort_ready_low", {31'd0, Req_Ready}, 32'd0);
         for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("abort_no_resp", {31'd0, Resp_Valid}, 32'd0);
         end
         rst_n = 1'b1;
         @(negedge clk);
         chk("abort_ready_back", {31'd0, Req_Ready}, 32'd1);
         chk("abort_no_resp_after", {31'd0, Resp_Valid}, 32'd0);
         chk("abort_no_write", wr_cnt - wr0, 32'd0);
         chk("abort_mem_intact", mem[8'h10], 32'hA53CA5A5);
      end

      begin
         vec_t v;
         v.wr = 0; v.size = 2'b00; v.uns = 1; v.addr = 10'h040; v.wdata = 32'h0;
         v.exp_rdata = 32'h000000A5; v.exp_err = 0; v.exp_lat = 3; v.exp_rd = 2; v.exp_wr = 0;
         v.chk_en = 0; v.chk_addr = 8'h00; v.chk_val = 32'h0;
         run_vec(100, v);
      end

      chk("strobe_overlap", overlap_cnt, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
